// File: rtl/cu_pkg.sv
// Shared encodings for the CU sequencer and the accumulator ALU:
// opcodes, sequencer states, ALU operation codes and the decoded control word.
package cu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_CLAC = 4'h5;
    localparam logic [3:0] OP_MUL4 = 4'h6;
    localparam logic [3:0] OP_DIV2 = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JMPZ = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMWAIT,
        ST_EXEC,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_PASS = 3'd2,
        ALU_ZER  = 3'd3,
        ALU_MUL4 = 3'd5,
        ALU_DIV2 = 3'd6
    } alu_op_t;

    typedef struct packed {
        logic    mem_access;
        logic    mem_write;
        alu_op_t alu_op;
        logic    ac_we;
        logic    jump;
        logic    jump_z;
        logic    z_capture;
        logic    halt;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-control decode for cu_sequencer.
// Opcode 9 decodes as JMPZ only when CU_JMPZ_EN is defined; otherwise it is a NOP.
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no opcode can leave a latch behind.
        ctrl = '0;
        case (opcode)
            OP_LDAC: begin
                ctrl.mem_access = 1'b1;
                ctrl.alu_op     = ALU_PASS;
                ctrl.ac_we      = 1'b1;
                ctrl.z_capture  = 1'b1;
            end
            OP_STAC: begin
                ctrl.mem_access = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            OP_ADD: begin
                ctrl.mem_access = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.ac_we      = 1'b1;
            end
            OP_SUB: begin
                ctrl.mem_access = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.ac_we      = 1'b1;
                ctrl.z_capture  = 1'b1;
            end
            OP_CLAC: begin
                ctrl.alu_op = ALU_ZER;
                ctrl.ac_we  = 1'b1;
            end
            OP_MUL4: begin
                ctrl.alu_op = ALU_MUL4;
                ctrl.ac_we  = 1'b1;
            end
            OP_DIV2: begin
                ctrl.alu_op = ALU_DIV2;
                ctrl.ac_we  = 1'b1;
            end
            OP_JMP:  ctrl.jump = 1'b1;
`ifdef CU_JMPZ_EN
            OP_JMPZ: ctrl.jump_z = 1'b1;
`endif
            OP_HALT: ctrl.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle control-unit sequencer: fetch / decode / memory wait / execute.
// Define CU_JMPZ_EN to enable the conditional jump (opcode 9) and the z_q flag register.
module cu_sequencer
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        flag_z,
    output logic [7:0]  pc,
    output logic [7:0]  operand,
    output logic        instr_rd,
    output logic        data_rd,
    output logic        data_wr,
    output logic [2:0]  alu_op,
    output logic        ac_we,
    output logic        busy,
    output logic        halted
);

    state_t     state;
    logic [3:0] ir_op;
    logic [7:0] ir_arg;
    ctrl_t      ctrl;
    logic       take_jump;

    cu_decode u_decode (
        .opcode (ir_op),
        .ctrl   (ctrl)
    );

    // The middle nibble of the instruction word carries no meaning for this unit.
    logic unused_instr;
    assign unused_instr = ^instr[11:8];

`ifdef CU_JMPZ_EN
    logic z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
        end else if (state == ST_EXEC && ctrl.z_capture) begin
            z_q <= flag_z;
        end
    end

    assign take_jump = ctrl.jump | (ctrl.jump_z & z_q);
`else
    logic unused_jmpz;
    assign unused_jmpz = ctrl.jump_z | ctrl.z_capture | flag_z;
    assign take_jump   = ctrl.jump;
`endif

    // Outputs are registered: each transition loads the strobes of the state being entered.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir_op    <= '0;
            ir_arg   <= '0;
            operand  <= '0;
            instr_rd <= 1'b0;
            data_rd  <= 1'b0;
            data_wr  <= 1'b0;
            alu_op   <= '0;
            ac_we    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        pc       <= '0;
                        instr_rd <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir_op    <= instr[15:12];
                        ir_arg   <= instr[7:0];
                        instr_rd <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    operand <= ir_arg;
                    if (ctrl.mem_access) begin
                        state   <= ST_MEMWAIT;
                        data_wr <= ctrl.mem_write;
                        data_rd <= ~ctrl.mem_write;
                    end else begin
                        state  <= ST_EXEC;
                        alu_op <= ctrl.alu_op;
                        ac_we  <= ctrl.ac_we;
                    end
                end
                ST_MEMWAIT: begin
                    if (mem_ready) begin
                        data_rd <= 1'b0;
                        data_wr <= 1'b0;
                        state   <= ST_EXEC;
                        alu_op  <= ctrl.alu_op;
                        ac_we   <= ctrl.ac_we;
                    end
                end
                ST_EXEC: begin
                    alu_op <= '0;
                    ac_we  <= 1'b0;
                    if (ctrl.halt) begin
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state    <= ST_FETCH;
                        instr_rd <= 1'b1;
                        pc       <= take_jump ? operand : pc + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios plus a random-program run
// compared against an instruction-level model of the sequencer.
module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready, flag_z;
    logic [15:0] instr;
    logic [7:0]  pc, operand;
    logic        instr_rd, data_rd, data_wr, ac_we, busy, halted;
    logic [2:0]  alu_op;

    logic [15:0] imem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Instruction memory answers combinationally at the current pc.
    always_comb instr = imem[pc];

    cu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .instr     (instr),
        .mem_ready (mem_ready),
        .flag_z    (flag_z),
        .pc        (pc),
        .operand   (operand),
        .instr_rd  (instr_rd),
        .data_rd   (data_rd),
        .data_wr   (data_wr),
        .alu_op    (alu_op),
        .ac_we     (ac_we),
        .busy      (busy),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; flag_z = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    // Expected behaviour of one opcode: memory kind (0 none, 1 read, 2 write), write strobe, ALU op.
    function automatic void exp_of(input logic [3:0] op, output int kind, output int we, output int alu);
        kind = 0; we = 0; alu = 0;
        case (op)
            4'h1: begin kind = 1; we = 1; alu = 2; end
            4'h2: kind = 2;
            4'h3: begin kind = 1; we = 1; alu = 0; end
            4'h4: begin kind = 1; we = 1; alu = 1; end
            4'h5: begin we = 1; alu = 3; end
            4'h6: begin we = 1; alu = 5; end
            4'h7: begin we = 1; alu = 6; end
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        if ($urandom_range(99) < 4) op = 4'hF;
        else op = 4'($urandom_range(14));
        return {op, 4'($urandom_range(15)), 8'($urandom_range(255))};
    endfunction

    // Instruction-level reference state for the random run.
    logic [7:0]  model_pc;
    logic        model_z;
    logic [15:0] cur;
    logic        in_win;
    int          win_kind, win_we;
    logic [2:0]  win_alu;
    logic [7:0]  win_addr;

    task automatic finalize();
        int kind, we, alu;
        logic [3:0] op;
        op = cur[15:12];
        exp_of(op, kind, we, alu);
        check("win_mem_kind", win_kind, kind);
        check("win_ac_we", win_we, we);
        if (we != 0) check("win_alu_op", {29'd0, win_alu}, alu);
        if (kind != 0) check("win_addr", {24'd0, win_addr}, {24'd0, cur[7:0]});
        if (op == 4'h8) model_pc = cur[7:0];
`ifdef CU_JMPZ_EN
        else if (op == 4'h9 && model_z) model_pc = cur[7:0];
`endif
        else if (op != 4'hF) model_pc = model_pc + 8'd1;
        in_win = 1'b0;
    endtask

    initial begin
        int         we_cnt;
        logic       we_at [16];
        logic [2:0] alu_at [16];
        logic       halt_at [16];
        logic [7:0] fetch_pc [$];
        int         fetch_cyc [$];
        logic       stall_rd, stall_pc, stall_we, seen_we;
        logic [2:0] seen_alu;
        logic [7:0] exp_pc;
        logic       started;

        clear_mem();

        // Reset wins over start and mem_ready in the same cycle.
        rst = 1'b1; start = 1'b1; mem_ready = 1'b1; flag_z = 1'b0;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_pc", {24'd0, pc}, 0);
        check("rst_operand", {24'd0, operand}, 0);
        check("rst_reqs", {29'd0, instr_rd, data_rd, data_wr}, 0);
        check("rst_strobe", {28'd0, ac_we, alu_op}, 0);
        check("rst_busy_halted", {30'd0, busy, halted}, 0);
        tick();
        check("idle_holds", {30'd0, busy, instr_rd}, 0);

        // LDAC 0x10; ADD 0x11; HALT with memory always ready; start pulsed during an EXEC.
        imem[0] = 16'h1010; imem[1] = 16'h3011; imem[2] = 16'hF000;
        mem_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        we_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            we_at[c] = ac_we; alu_at[c] = alu_op; halt_at[c] = halted;
            if (ac_we) we_cnt++;
            start = (c == 4);
            tick();
        end
        start = 1'b0;
        check("prog_we_c4", {31'd0, we_at[4]}, 1);
        check("prog_alu_c4", {29'd0, alu_at[4]}, 2);
        check("prog_we_c8", {31'd0, we_at[8]}, 1);
        check("prog_alu_c8", {29'd0, alu_at[8]}, 0);
        check("prog_we_count", we_cnt, 2);
        check("prog_halted_c12", {31'd0, halt_at[12]}, 1);
        check("prog_halted_c14", {31'd0, halt_at[14]}, 1);
        check("prog_halt_pc", {24'd0, pc}, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_pc", {24'd0, pc}, 0);
        check("restart_fetch", {29'd0, instr_rd, busy, halted}, 3'b110);

        // Reset in the middle of a stalled LDAC data read.
        do_reset();
        clear_mem();
        imem[0] = 16'h1020;
        start = 1'b1; mem_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("mw_rd_before", {31'd0, data_rd}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mw_rst_rd", {31'd0, data_rd}, 0);
        check("mw_rst_pc", {24'd0, pc}, 0);
        check("mw_rst_idle", {30'd0, busy, halted}, 0);

        // Fetch stalled for 5 cycles, then a CLAC completes.
        do_reset();
        imem[0] = 16'h5000;
        start = 1'b1; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        stall_rd = 1'b1; stall_pc = 1'b1; stall_we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stall_rd &= instr_rd;
            stall_pc &= (pc == 8'd0);
            stall_we |= ac_we;
            tick();
        end
        check("stall_instr_rd", {31'd0, stall_rd}, 1);
        check("stall_pc", {31'd0, stall_pc}, 1);
        check("stall_no_we", {31'd0, stall_we}, 0);
        mem_ready = 1'b1;
        seen_we = 1'b0; seen_alu = '0;
        for (int c = 0; c < 10 && !seen_we; c++) begin
            if (ac_we) begin seen_we = 1'b1; seen_alu = alu_op; end
            else tick();
        end
        check("clac_we", {31'd0, seen_we}, 1);
        check("clac_alu", {29'd0, seen_alu}, 3);

        // SUB then JMPZ 0x40, with the zero flag set and clear.
        for (int fz = 1; fz >= 0; fz--) begin
            do_reset();
            clear_mem();
            imem[0] = 16'h4030; imem[1] = 16'h9040; imem[2] = 16'hF000; imem[8'h40] = 16'hF000;
            flag_z = fz[0]; mem_ready = 1'b1; start = 1'b1;
            tick();
            start = 1'b0;
            wait_halt(40);
`ifdef CU_JMPZ_EN
            exp_pc = fz[0] ? 8'h40 : 8'h02;
`else
            exp_pc = 8'h02;
`endif
            check(fz[0] ? "jmpz_z1_pc" : "jmpz_z0_pc", {24'd0, pc}, {24'd0, exp_pc});
        end

        // pc wrap at 0xFF and an undefined opcode behaving as NOP.
        do_reset();
        clear_mem();
        imem[0] = 16'h80FE; imem[8'hFE] = 16'hB0AA; imem[8'hFF] = 16'h0000;
        mem_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        seen_we = 1'b0;
        for (int c = 0; c < 40 && fetch_pc.size() < 4; c++) begin
            if (instr_rd) begin fetch_pc.push_back(pc); fetch_cyc.push_back(c); end
            seen_we |= ac_we;
            tick();
        end
        check("wrap_fetch_count", fetch_pc.size(), 4);
        if (fetch_pc.size() == 4) begin
            check("wrap_pc0", {24'd0, fetch_pc[0]}, 32'h00);
            check("wrap_pc1", {24'd0, fetch_pc[1]}, 32'hFE);
            check("wrap_pc2", {24'd0, fetch_pc[2]}, 32'hFF);
            check("wrap_pc3", {24'd0, fetch_pc[3]}, 32'h00);
            check("nonmem_latency", fetch_cyc[1] - fetch_cyc[0], 3);
        end
        check("wrap_no_we", {31'd0, seen_we}, 0);

        // Random programs against the instruction-level model.
        for (int i = 0; i < 256; i++) imem[i] = rand_instr();
        do_reset();
        model_pc = 8'd0; model_z = 1'b0; in_win = 1'b0; started = 1'b0;
        cur = '0; win_kind = 0; win_we = 0; win_alu = '0; win_addr = '0;
        for (int c = 0; c < 4000; c++) begin
            mem_ready = ($urandom_range(3) != 0);
            flag_z    = 1'($urandom_range(1));
            start     = ($urandom_range(7) == 0);
            if (in_win && halted) begin
                finalize();
                check("halt_pc", {24'd0, pc}, {24'd0, model_pc});
            end
            if (instr_rd && mem_ready) begin
                if (in_win) finalize();
                check("fetch_pc", {24'd0, pc}, {24'd0, model_pc});
                cur = imem[model_pc];
                in_win = 1'b1; win_kind = 0; win_we = 0; win_alu = '0; win_addr = '0;
            end
            if (data_rd || data_wr) begin
                win_kind = data_wr ? 2 : 1;
                win_addr = operand;
            end
            if (ac_we) begin
                win_we++;
                win_alu = alu_op;
                if (cur[15:12] == 4'h1 || cur[15:12] == 4'h4) model_z = flag_z;
            end
            check("req_exclusive", {31'd0, (32'(instr_rd) + 32'(data_rd) + 32'(data_wr)) <= 1}, 1);
            if (!ac_we) check("alu_idle", {29'd0, alu_op}, 0);
            if (started) check("busy_xor_halted", {31'd0, busy ^ halted}, 1);
            if (!busy && start) begin
                model_pc = 8'd0;
                started  = 1'b1;
            end
            tick();
        end
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
